// File: rtl/riscv_v_vstore_seq_pkg.sv
// Shared widths, state encoding and memory-beat payload for the vector store sequencer.
package riscv_v_vstore_seq_pkg;

    localparam int unsigned VLEN       = 128;
    localparam int unsigned MEM_DW     = 32;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned NUM_BEATS  = VLEN / MEM_DW;
    localparam int unsigned NUM_BYTES  = VLEN / BYTE_W;
    localparam int unsigned BEAT_BYTES = MEM_DW / BYTE_W;
    localparam int unsigned BEAT_W     = $clog2(NUM_BEATS);
    localparam int unsigned BEAT_IW    = BEAT_W + 1;
    localparam int unsigned REG_AW     = 5;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned LEN_W      = 5;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } vstore_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]     addr;
        logic [MEM_DW-1:0]     wdata;
        logic [BEAT_BYTES-1:0] wstrb;
    } mem_beat_t;

    // Per-byte enables: length clamped to the register size, optionally gated by v0.
    function automatic logic [NUM_BYTES-1:0] byte_enables(
        input logic [LEN_W-1:0]     num_bytes,
        input logic                 masked,
        input logic [NUM_BYTES-1:0] mask
    );
        logic [LEN_W-1:0]     len;
        logic [NUM_BYTES-1:0] en;
        len = (num_bytes > LEN_W'(NUM_BYTES)) ? LEN_W'(NUM_BYTES) : num_bytes;
        en  = '0;
        for (int i = 0; i < int'(NUM_BYTES); i++) begin
            en[i] = (LEN_W'(i) < len) && (!masked || mask[i]);
        end
        return en;
    endfunction

endpackage

// File: rtl/riscv_v_vstore_next_beat.sv
// Priority finder: lowest beat index >= from_i whose strobe group is nonzero.
module riscv_v_vstore_next_beat
    import riscv_v_vstore_seq_pkg::*;
(
    input  logic [NUM_BYTES-1:0] en_i,
    input  logic [BEAT_IW-1:0]   from_i,
    output logic [BEAT_W-1:0]    beat_o,
    output logic                 found_o
);

    // Scan downward so the lowest qualifying beat wins.
    always_comb begin
        beat_o  = '0;
        found_o = 1'b0;
        for (int b = int'(NUM_BEATS) - 1; b >= 0; b--) begin
            if ((BEAT_IW'(b) >= from_i) && (|en_i[b*int'(BEAT_BYTES) +: BEAT_BYTES])) begin
                beat_o  = BEAT_W'(b);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/riscv_v_vstore_seq.sv
// Vector store sequencer: snapshots one vector register plus v0 mask and streams
// the enabled bytes to the memory write port as word beats, skipping empty beats.
module riscv_v_vstore_seq
    import riscv_v_vstore_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [REG_AW-1:0]     req_vs,
    input  logic [ADDR_W-1:0]     req_base_addr,
    input  logic [LEN_W-1:0]      req_num_bytes,
    input  logic                  req_masked,
    output logic [REG_AW-1:0]     rf_rd_addr,
    input  logic [VLEN-1:0]       rf_rd_data,
    input  logic [NUM_BYTES-1:0]  rf_mask,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [MEM_DW-1:0]     mem_wdata,
    output logic [BEAT_BYTES-1:0] mem_wstrb,
    output logic                  done
);

    vstore_state_t        state_q, state_d;
    logic [VLEN-1:0]      buf_q, buf_d;
    logic [NUM_BYTES-1:0] en_q, en_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;

    mem_beat_t            out_q, out_d;
    logic                 mem_valid_q, mem_valid_d;
    logic                 req_ready_q, req_ready_d;
    logic                 done_q, done_d;

    logic [NUM_BYTES-1:0] en_cap;
    logic [BEAT_W-1:0]    first_beat, next_beat;
    logic                 first_found, next_found;

    assign en_cap     = byte_enables(req_num_bytes, req_masked, rf_mask);
    assign rf_rd_addr = (state_q == IDLE) ? req_vs : '0;

    riscv_v_vstore_next_beat u_first (
        .en_i    (en_cap),
        .from_i  ('0),
        .beat_o  (first_beat),
        .found_o (first_found)
    );

    riscv_v_vstore_next_beat u_next (
        .en_i    (en_q),
        .from_i  (BEAT_IW'(beat_q) + BEAT_IW'(1)),
        .beat_o  (next_beat),
        .found_o (next_found)
    );

    // Next-state logic; output registers are loaded from the next-state view.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        en_d        = en_q;
        base_d      = base_q;
        beat_d      = beat_q;
        out_d       = '0;
        mem_valid_d = 1'b0;
        req_ready_d = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    buf_d  = rf_rd_data;
                    en_d   = en_cap;
                    base_d = req_base_addr & ~ADDR_W'(BEAT_BYTES - 1);
                    if (first_found) begin
                        state_d = SEND;
                        beat_d  = first_beat;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SEND: begin
                if (mem_valid_q && mem_ready) begin
                    if (next_found) begin
                        beat_d = next_beat;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == SEND) begin
            mem_valid_d = 1'b1;
            out_d.addr  = base_d + ADDR_W'(beat_d) * ADDR_W'(BEAT_BYTES);
            out_d.wdata = buf_d[int'(beat_d)*int'(MEM_DW) +: MEM_DW];
            out_d.wstrb = en_d[int'(beat_d)*int'(BEAT_BYTES) +: BEAT_BYTES];
        end
        req_ready_d = (state_d == IDLE);
        done_d      = (state_d == DONE);
    end

    // State and output registers; reset aborts any store in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            en_q        <= '0;
            base_q      <= '0;
            beat_q      <= '0;
            out_q       <= '0;
            mem_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            en_q        <= en_d;
            base_q      <= base_d;
            beat_q      <= beat_d;
            out_q       <= out_d;
            mem_valid_q <= mem_valid_d;
            req_ready_q <= req_ready_d;
            done_q      <= done_d;
        end
    end

    assign req_ready = req_ready_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = out_q.addr;
    assign mem_wdata = out_q.wdata;
    assign mem_wstrb = out_q.wstrb;
    assign done      = done_q;

endmodule
